// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, qualifies the synchronised lock flag,
// then enables the PLL output clocks one at a time and watches for lock loss.
module pll_lock_supervisor #(
  parameter int N_CLKS           = 3,
  parameter int RST_PULSE_CYC    = 4,
  parameter int LOCK_STABLE_CYC  = 8,
  parameter int LOCK_TIMEOUT_CYC = 32,
  parameter int MAX_RETRIES      = 2,
  parameter int STAGGER_CYC      = 2,
  parameter int CNT_W            = 8
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              pll_locked_i,
  input  logic              relock_req,
  output logic              pll_rst_o,
  output logic [N_CLKS-1:0] clk_en_o,
  output logic              ready_o,
  output logic              fault_o,
  output logic [2:0]        state_o,
  output logic [CNT_W-1:0]  loss_cnt_o
);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_ENABLE    = 3'd3,
    S_RUN       = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  localparam logic [15:0]       RST_LAST  = 16'(RST_PULSE_CYC - 1);
  localparam logic [15:0]       TMO_LAST  = 16'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [15:0]       STB_LAST  = 16'(LOCK_STABLE_CYC - 1);
  localparam logic [15:0]       STG_LAST  = 16'(STAGGER_CYC - 1);
  localparam logic [7:0]        RETRY_MAX = 8'(MAX_RETRIES);
  localparam logic [N_CLKS-1:0] EN_FIRST  = N_CLKS'(1);
  localparam logic [CNT_W-1:0]  LOSS_MAX  = {CNT_W{1'b1}};

  state_t            r_state;
  logic              r_sync1;
  logic              r_sync2;
  logic [15:0]       r_timer;
  logic [7:0]        r_retry;
  logic [N_CLKS-1:0] r_en;
  logic              r_pll_rst;
  logic              r_ready;
  logic              r_fault;
  logic [CNT_W-1:0]  r_loss;
  logic              w_lock;

  assign w_lock = r_sync2;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pll_locked_i;
      r_sync2 <= r_sync1;
    end
  end

  // relock_req outranks every per-state decision, including a same-cycle lock loss
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_RESET_PLL;
      r_timer   <= '0;
      r_retry   <= '0;
      r_en      <= '0;
      r_pll_rst <= 1'b1;
      r_ready   <= 1'b0;
      r_fault   <= 1'b0;
      r_loss    <= '0;
    end else if (relock_req && (r_state != S_RESET_PLL)) begin
      r_state   <= S_RESET_PLL;
      r_timer   <= '0;
      r_retry   <= '0;
      r_en      <= '0;
      r_pll_rst <= 1'b1;
      r_ready   <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      case (r_state)
        S_RESET_PLL: begin
          if (r_timer == RST_LAST) begin
            r_state   <= S_WAIT_LOCK;
            r_timer   <= '0;
            r_pll_rst <= 1'b0;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        S_WAIT_LOCK: begin
          if (w_lock) begin
            r_state <= S_STABLE;
            r_timer <= '0;
          end else if (r_timer == TMO_LAST) begin
            r_timer   <= '0;
            r_retry   <= r_retry + 8'd1;
            r_pll_rst <= 1'b1;
            if ((r_retry + 8'd1) == RETRY_MAX) begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
            end else begin
              r_state <= S_RESET_PLL;
            end
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        S_STABLE: begin
          if (!w_lock) begin
            r_state <= S_WAIT_LOCK;
            r_timer <= '0;
          end else if (r_timer == STB_LAST) begin
            r_state <= S_ENABLE;
            r_timer <= '0;
            r_en    <= EN_FIRST;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        S_ENABLE, S_RUN: begin
          if (!w_lock) begin
            r_state   <= S_RESET_PLL;
            r_timer   <= '0;
            r_en      <= '0;
            r_pll_rst <= 1'b1;
            r_ready   <= 1'b0;
            if (r_loss != LOSS_MAX) begin
              r_loss <= r_loss + CNT_W'(1);
            end
          end else if (r_state == S_ENABLE) begin
            // the top bit being set means every output is on; RUN follows one cycle later
            if (r_en[N_CLKS-1]) begin
              r_state <= S_RUN;
              r_timer <= '0;
              r_retry <= '0;
              r_ready <= 1'b1;
            end else if (r_timer == STG_LAST) begin
              r_timer <= '0;
              r_en    <= r_en | (r_en << 1);
            end else begin
              r_timer <= r_timer + 16'd1;
            end
          end
        end
        S_FAULT: begin
          r_pll_rst <= 1'b1;
          r_fault   <= 1'b1;
        end
        default: begin
          r_state   <= S_RESET_PLL;
          r_timer   <= '0;
          r_en      <= '0;
          r_pll_rst <= 1'b1;
          r_ready   <= 1'b0;
          r_fault   <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst_o  = r_pll_rst;
  assign clk_en_o   = r_en;
  assign ready_o    = r_ready;
  assign fault_o    = r_fault;
  assign state_o    = r_state;
  assign loss_cnt_o = r_loss;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench: each scenario queues the per-cycle outputs it expects,
// and a sampler pops and compares one entry shortly after every rising edge.
module tb_pll_lock_supervisor;

  localparam int RST_CYC = 4;
  localparam int STB_CYC = 8;
  localparam int TMO_CYC = 32;
  localparam int STG_CYC = 2;

  typedef struct {
    string       tag;
    logic [16:0] val;
  } expect_t;

  logic refclk;
  logic sel;
  int   vecCount;
  int   errCount;
  expect_t sbQ[$];

  logic       rst1N, pll1, relock1;
  logic       pllRst1, ready1, fault1;
  logic [2:0] en1, state1;
  logic [7:0] loss1;

  logic       rst2N, pll2, relock2;
  logic       pllRst2, ready2, fault2;
  logic [0:0] en2;
  logic [2:0] state2;
  logic [1:0] loss2;

  pll_lock_supervisor dut1 (
    .refclk(refclk), .rst_n(rst1N), .pll_locked_i(pll1), .relock_req(relock1),
    .pll_rst_o(pllRst1), .clk_en_o(en1), .ready_o(ready1), .fault_o(fault1),
    .state_o(state1), .loss_cnt_o(loss1)
  );

  pll_lock_supervisor #(.N_CLKS(1), .CNT_W(2)) dut2 (
    .refclk(refclk), .rst_n(rst2N), .pll_locked_i(pll2), .relock_req(relock2),
    .pll_rst_o(pllRst2), .clk_en_o(en2), .ready_o(ready2), .fault_o(fault2),
    .state_o(state2), .loss_cnt_o(loss2)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  function automatic logic [16:0] mk(input logic [2:0] st, input logic [2:0] en,
                                     input logic rst, input logic rdy, input logic flt,
                                     input logic [7:0] loss);
    return {st, en, rst, rdy, flt, loss};
  endfunction

  function automatic logic [16:0] observed();
    if (sel)
      return {state2, 2'b00, en2, pllRst2, ready2, fault2, 6'b0, loss2};
    return {state1, en1, pllRst1, ready1, fault1, loss1};
  endfunction

  task automatic checkOutput(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    vecCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got st=%0d en=%b rst=%b rdy=%b flt=%b loss=%0d, expected st=%0d en=%b rst=%b rdy=%b flt=%b loss=%0d",
               tag, obs[16:14], obs[13:11], obs[10], obs[9], obs[8], obs[7:0],
               exp[16:14], exp[13:11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic applyStimulus(input logic rstN, input logic locked, input logic relock);
    if (sel) begin
      rst2N = rstN; pll2 = locked; relock2 = relock;
    end else begin
      rst1N = rstN; pll1 = locked; relock1 = relock;
    end
  endtask

  task automatic pushSeg(input string tag, input logic [2:0] st, input logic [2:0] en,
                         input logic rst, input logic rdy, input logic flt,
                         input logic [7:0] loss, input int n);
    expect_t e;
    for (int i = 0; i < n; i++) begin
      e.tag = $sformatf("%s#%0d", tag, sbQ.size());
      e.val = mk(st, en, rst, rdy, flt, loss);
      sbQ.push_back(e);
    end
  endtask

  // WAIT_LOCK for one cycle (lock already high), STABLE, staggered ENABLE, first RUN cycle
  task automatic pushBringup(input string tag, input int nClks, input logic [7:0] loss);
    logic [2:0] e;
    pushSeg(tag, 3'd1, 3'b000, 1'b0, 1'b0, 1'b0, loss, 1);
    pushSeg(tag, 3'd2, 3'b000, 1'b0, 1'b0, 1'b0, loss, STB_CYC);
    for (int k = 0; k < nClks; k++) begin
      e = 3'((1 << (k + 1)) - 1);
      pushSeg(tag, 3'd3, e, 1'b0, 1'b0, 1'b0, loss, (k == nClks - 1) ? 1 : STG_CYC);
    end
    e = 3'((1 << nClks) - 1);
    pushSeg(tag, 3'd4, e, 1'b0, 1'b1, 1'b0, loss, 1);
  endtask

  task automatic pushReset(input string tag, input logic [7:0] loss, input int n);
    pushSeg(tag, 3'd0, 3'b000, 1'b1, 1'b0, 1'b0, loss, n);
  endtask

  task automatic waitNeg(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic waitDrain();
    int guard;
    guard = 0;
    while (sbQ.size() > 0 && guard < 3000) begin
      @(negedge refclk);
      guard++;
    end
    if (sbQ.size() > 0) begin
      checkOutput("drainTimeout", 17'(sbQ.size()), 17'd0);
      sbQ.delete();
    end
    @(negedge refclk);
  endtask

  initial begin
    expect_t e;
    forever begin
      @(posedge refclk);
      #2;
      if (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        checkOutput(e.tag, observed(), e.val);
      end
    end
  end

  initial begin
    vecCount = 0; errCount = 0; sel = 1'b0;
    rst1N = 1'b0; pll1 = 1'b1; relock1 = 1'b0;
    rst2N = 1'b0; pll2 = 1'b1; relock2 = 1'b0;

    @(negedge refclk);
    pushReset("rst1", 8'd0, 1);
    waitDrain();

    $display("[TB] power-up bring-up");
    applyStimulus(1'b1, 1'b1, 1'b0);
    pushReset("up", 8'd0, RST_CYC - 1);
    pushBringup("up", 3, 8'd0);
    waitDrain();

    $display("[TB] one-cycle lock drop in RUN");
    pushSeg("drop", 3'd4, 3'b111, 1'b0, 1'b1, 1'b0, 8'd0, 2);
    pushReset("drop", 8'd1, RST_CYC);
    pushBringup("drop", 3, 8'd1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitNeg(1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitDrain();

    $display("[TB] relock then glitch at fifth STABLE cycle");
    pushReset("glitch", 8'd1, RST_CYC);
    pushSeg("glitch", 3'd1, 3'b000, 1'b0, 1'b0, 1'b0, 8'd1, 1);
    pushSeg("glitch", 3'd2, 3'b000, 1'b0, 1'b0, 1'b0, 8'd1, 5);
    pushBringup("glitch", 3, 8'd1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitNeg(1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitNeg(7);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitNeg(1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitDrain();

    $display("[TB] relock coinciding with lock loss");
    pushSeg("both", 3'd4, 3'b111, 1'b0, 1'b1, 1'b0, 8'd1, 2);
    pushReset("both", 8'd1, RST_CYC);
    pushBringup("both", 3, 8'd1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitNeg(1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitNeg(1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitNeg(1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitDrain();

    $display("[TB] lock held low until FAULT, then relock");
    pushSeg("tmo", 3'd4, 3'b111, 1'b0, 1'b1, 1'b0, 8'd1, 2);
    pushReset("tmo", 8'd2, RST_CYC);
    pushSeg("tmo", 3'd1, 3'b000, 1'b0, 1'b0, 1'b0, 8'd2, TMO_CYC);
    pushReset("tmo", 8'd2, RST_CYC);
    pushSeg("tmo", 3'd1, 3'b000, 1'b0, 1'b0, 1'b0, 8'd2, TMO_CYC);
    pushSeg("tmo", 3'd5, 3'b000, 1'b1, 1'b0, 1'b1, 8'd2, 3);
    pushReset("tmo", 8'd2, RST_CYC);
    pushBringup("tmo", 3, 8'd2);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitNeg(2 + RST_CYC + TMO_CYC + RST_CYC + TMO_CYC + 3);
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitNeg(1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitDrain();

    $display("[TB] async reset mid-ENABLE");
    pushReset("midEn", 8'd2, RST_CYC);
    pushSeg("midEn", 3'd1, 3'b000, 1'b0, 1'b0, 1'b0, 8'd2, 1);
    pushSeg("midEn", 3'd2, 3'b000, 1'b0, 1'b0, 1'b0, 8'd2, STB_CYC);
    pushSeg("midEn", 3'd3, 3'b001, 1'b0, 1'b0, 1'b0, 8'd2, STG_CYC);
    pushSeg("midEn", 3'd3, 3'b011, 1'b0, 1'b0, 1'b0, 8'd2, 1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitNeg(1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitNeg(RST_CYC + 1 + STB_CYC + STG_CYC + 1 - 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("asyncRst", observed(), mk(3'd0, 3'b000, 1'b1, 1'b0, 1'b0, 8'd0));
    waitDrain();

    $display("[TB] single-clock, 2-bit loss counter instance");
    sel = 1'b1;
    pushReset("rst2", 8'd0, 1);
    waitDrain();
    applyStimulus(1'b1, 1'b1, 1'b0);
    pushReset("up2", 8'd0, RST_CYC - 1);
    pushBringup("up2", 1, 8'd0);
    waitDrain();
    for (int l = 0; l < 5; l++) begin
      pushSeg("sat", 3'd4, 3'b001, 1'b0, 1'b1, 1'b0, 8'(l > 3 ? 3 : l), 2);
      pushReset("sat", 8'(l + 1 > 3 ? 3 : l + 1), RST_CYC);
      pushBringup("sat", 1, 8'(l + 1 > 3 ? 3 : l + 1));
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitNeg(1);
      applyStimulus(1'b1, 1'b1, 1'b0);
      waitDrain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 Parameter N_CLKS, default 3: number of PLL output clocks gated by this block, range 1..18.
REQ-002 Parameter RST_PULSE_CYC, default 4: PLL reset pulse length in refclk cycles, minimum 1.
REQ-003 Parameter LOCK_STABLE_CYC, default 8: consecutive synchronised-lock cycles required before enabling outputs, minimum 1.
REQ-004 Parameter LOCK_TIMEOUT_CYC, default 32: cycles allowed in WAIT_LOCK before a retry, minimum 2.
REQ-005 Parameter MAX_RETRIES, default 2: lock timeouts tolerated before FAULT, minimum 1.
REQ-006 Parameter STAGGER_CYC, default 2: cycles between successive output-enable assertions, minimum 1.
REQ-007 Parameter CNT_W, default 8: width of the lock-loss counter.
REQ-008 refclk  input  1  sole clock; all logic is on its rising edge.
REQ-009 rst_n  input  1  asynchronous, active-low reset.
REQ-010 pll_locked_i  input  1  raw PLL locked flag, asynchronous to refclk.
REQ-011 relock_req  input  1  single-cycle request to force a full PLL re-lock sequence.
REQ-012 pll_rst_o  output  1  active-high reset to the PLL.
REQ-013 clk_en_o  output  N_CLKS  per-output-clock enable; bit k gates PLL output k.
REQ-014 ready_o  output  1  high only in RUN.
REQ-015 fault_o  output  1  high only in FAULT.
REQ-016 state_o  output  3  current state encoding.
REQ-017 loss_cnt_o  output  CNT_W  count of lock losses after outputs were enabled.

Function
REQ-018 pll_locked_i shall pass through a 2-flop synchroniser; "lock" below means the synchronised value; all outputs are registered.
REQ-019 States and encodings: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, ENABLE=3, RUN=4, FAULT=5; other codes shall return to RESET_PLL on the next cycle.
REQ-020 RESET_PLL: pll_rst_o=1 and clk_en_o=0 for exactly RST_PULSE_CYC cycles, then go to WAIT_LOCK with the timer cleared.
REQ-021 WAIT_LOCK: pll_rst_o=0; lock=1 goes to STABLE; the timer reaching LOCK_TIMEOUT_CYC increments the retry count and goes to FAULT if the count equals MAX_RETRIES, otherwise to RESET_PLL.
REQ-022 STABLE: after LOCK_STABLE_CYC consecutive lock=1 cycles, go to ENABLE; any lock=0 returns to WAIT_LOCK with the timer restarted and the retry count unchanged.
REQ-023 ENABLE: set clk_en_o[0] on entry and set bit k exactly STAGGER_CYC cycles after bit k-1; enter RUN on the cycle after bit N_CLKS-1 is set; already-set bits stay set.
REQ-024 Entering RUN shall clear the retry count.
REQ-025 Lock loss in ENABLE or RUN: on the next cycle clear all of clk_en_o, increment loss_cnt_o (saturating at all-ones), and go to RESET_PLL.
REQ-026 FAULT: pll_rst_o=1, clk_en_o=0, fault_o=1; exit only on relock_req.
REQ-027 relock_req in any state except RESET_PLL: go to RESET_PLL next cycle, clear clk_en_o, clear the retry count, and leave loss_cnt_o unchanged; relock_req in RESET_PLL is ignored.
REQ-028 relock_req and lock loss in the same cycle: relock_req wins and loss_cnt_o is not incremented.
REQ-029 N_CLKS=1: ENABLE lasts one cycle; clk_en_o[0] and the transition to RUN follow REQ-023.

Reset
REQ-030 While rst_n=0: state=RESET_PLL, pll_rst_o=1, clk_en_o=0, ready_o=0, fault_o=0, loss_cnt_o=0, timers, retry count and synchroniser=0.
REQ-031 On rst_n release, the RST_PULSE_CYC count shall start at the first rising edge; asserting rst_n mid-sequence shall abort immediately to the REQ-030 values.

Verification (defaults)
REQ-032 Release reset with pll_locked_i=1 -> pll_rst_o high 4 cycles; clk_en_o goes 001, 011, 111 at 2-cycle spacing after 8 stable cycles; ready_o=1 the cycle after 111; state_o=4.
REQ-033 In RUN, drop pll_locked_i for 1 cycle -> 2 cycles of sync delay, then clk_en_o=000, loss_cnt_o=1, state_o=0; the sequence then restarts and reaches RUN again.
REQ-034 Hold pll_locked_i=0 -> two 32-cycle timeouts separated by a 4-cycle pll_rst_o pulse, then state_o=5, fault_o=1, pll_rst_o=1; relock_req -> state_o=0 and fault_o=0 next cycle.
REQ-035 In STABLE, glitch lock low at the 5th stable cycle -> state_o=1 with no retry increment; 8 fresh stable cycles are required before ENABLE.
REQ-036 In RUN, relock_req together with lock loss -> state_o=0, loss_cnt_o unchanged; with CNT_W=2, force 5 losses -> loss_cnt_o saturates at 3.
REQ-037 Assert rst_n=0 mid-ENABLE with clk_en_o=011 -> all outputs at REQ-030 values asynchronously.
